// File: rtl/spi_out_pkg.sv
// Shared types and constants for the SPI output scheduler and the outputSPI serializer.
package spi_out_pkg;

  localparam int unsigned BYTE_W          = 8;
  localparam int unsigned DEF_BYTE_CYCLES = 2;
  localparam int unsigned DEF_GAP_CYCLES  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  typedef struct packed {
    logic              last;
    logic [BYTE_W-1:0] data;
  } beat_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin winner select; the pointer moves to the other requester on update.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  input  logic       upd_owner_i,
  output logic [1:0] winner_c
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (upd_i) ptr_d = ~upd_owner_i;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end

  // A lone requester wins outright; the pointer only breaks ties.
  always_comb begin
    winner_c = req_i;
    if (&req_i) winner_c = ptr_q ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/spi_out_scheduler.sv
// Frame-level scheduler sharing the outputSPI serializer between two byte-stream requesters,
// pacing loads at the serializer byte rate and inserting an idle gap between frames.
module spi_out_scheduler
  import spi_out_pkg::*;
#(
  parameter int unsigned BYTE_CYCLES = DEF_BYTE_CYCLES,
  parameter int unsigned GAP_CYCLES  = DEF_GAP_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [BYTE_W-1:0] req0_data,
  input  logic              req0_last,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [BYTE_W-1:0] req1_data,
  input  logic              req1_last,
  output logic              req1_ready,
  output logic              ser_en,
  output logic [BYTE_W-1:0] ser_in,
  output logic [1:0]        grant,
  output logic              frame_active
);

  localparam int unsigned GAP_MAX = BYTE_CYCLES - 1 + GAP_CYCLES;
  localparam int unsigned TMR_W   = (BYTE_CYCLES > 1) ? $clog2(BYTE_CYCLES) : 1;
  localparam int unsigned GAP_W   = (GAP_MAX > 1) ? $clog2(GAP_MAX + 1) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(BYTE_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_MAX);

  state_e            state_q,  state_d;
  logic [1:0]        grant_q,  grant_d;
  logic              ser_en_q, ser_en_d;
  logic [BYTE_W-1:0] ser_in_q, ser_in_d;
  logic [TMR_W-1:0]  tmr_q,    tmr_d;
  logic [GAP_W-1:0]  gap_q,    gap_d;

  beat_t      sel_beat;
  logic       sel_valid;
  logic       accept;
  logic [1:0] winner;

  // Mux the granted requester's beat; grant_q is one-hot while a frame is owned.
  always_comb begin
    sel_beat.data = req0_data;
    sel_beat.last = req0_last;
    if (grant_q[1]) begin
      sel_beat.data = req1_data;
      sel_beat.last = req1_last;
    end
  end

  assign sel_valid  = (grant_q[0] & req0_valid) | (grant_q[1] & req1_valid);
  assign accept     = (state_q == ST_SEND) && sel_valid && (tmr_q == '0);
  assign req0_ready = accept & grant_q[0];
  assign req1_ready = accept & grant_q[1];

  rr_arbiter2 u_arb (
    .clk         (clk),
    .rst         (rst),
    .req_i       ({req1_valid, req0_valid}),
    .upd_i       (accept & sel_beat.last),
    .upd_owner_i (grant_q[1]),
    .winner_c    (winner)
  );

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    ser_en_d = 1'b0;
    ser_in_d = ser_in_q;
    tmr_d    = (tmr_q != '0) ? tmr_q - TMR_W'(1) : tmr_q;
    gap_d    = (gap_q != '0) ? gap_q - GAP_W'(1) : gap_q;

    unique case (state_q)
      ST_IDLE: begin
        if (|winner) begin
          state_d = ST_SEND;
          grant_d = winner;
        end
      end
      ST_SEND: begin
        if (accept) begin
          ser_en_d = 1'b1;
          ser_in_d = sel_beat.data;
          tmr_d    = TMR_LOAD;
          if (sel_beat.last) begin
            state_d = ST_GAP;
            gap_d   = GAP_LOAD;
          end
        end
      end
      ST_GAP: begin
        // Leave as the counter reaches zero; a zero load still costs one GAP cycle.
        if (gap_q <= GAP_W'(1)) begin
          state_d = ST_IDLE;
          grant_d = 2'b00;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= 2'b00;
      ser_en_q <= 1'b0;
      ser_in_q <= '0;
      tmr_q    <= '0;
      gap_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      ser_en_q <= ser_en_d;
      ser_in_q <= ser_in_d;
      tmr_q    <= tmr_d;
      gap_q    <= gap_d;
    end
  end

  assign grant        = grant_q;
  assign ser_en       = ser_en_q;
  assign ser_in       = ser_in_q;
  assign frame_active = (state_q == ST_SEND);

endmodule
